// File: rtl/aes128_iter_ctrl_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 controller.
// The S-box is computed (inverse then affine map) rather than stored as a table.
package aes128_iter_ctrl_pkg;

    localparam int NR    = 10;
    localparam int BLK_W = 128;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(gmul(x15, x15), gmul(x15, x15));
        x240 = gmul(gmul(x240, x240), gmul(x240, x240));
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes128_iter_ctrl_if.sv
// Host-side block interface: input pair handshake, ciphertext handshake and status.
interface aes128_iter_ctrl_if;
    import aes128_iter_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] pt_in;
    logic [BLK_W-1:0] key_in;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] ct_out;
    logic             busy;
    logic [3:0]       round_o;

    modport master (
        output in_valid, pt_in, key_in, out_ready,
        input  in_ready, out_valid, ct_out, busy, round_o
    );

    modport slave (
        input  in_valid, pt_in, key_in, out_ready,
        output in_ready, out_valid, ct_out, busy, round_o
    );

endinterface

// File: rtl/AES_Enc.sv
// Single combinational AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// MixColumns is bypassed when round == 10.
module AES_Enc
    import aes128_iter_ctrl_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [3:0]   round,
    output logic [127:0] state_out
);

    logic [7:0]   w_sub   [16];
    logic [7:0]   w_shift [16];
    logic [7:0]   w_mix   [16];
    logic [127:0] w_pre;

    always_comb begin
        for (int k = 0; k < 16; k++) w_sub[k] = sbox(state_in[127-8*k -: 8]);
    end

    // Byte k sits in column k/4, row k%4; row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_shift[4*c+r] = w_sub[4*((c+r)%4)+r];
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_mix[4*c]   = xtime(w_shift[4*c]) ^ xtime(w_shift[4*c+1]) ^ w_shift[4*c+1]
                         ^ w_shift[4*c+2] ^ w_shift[4*c+3];
            w_mix[4*c+1] = w_shift[4*c] ^ xtime(w_shift[4*c+1]) ^ xtime(w_shift[4*c+2])
                         ^ w_shift[4*c+2] ^ w_shift[4*c+3];
            w_mix[4*c+2] = w_shift[4*c] ^ w_shift[4*c+1] ^ xtime(w_shift[4*c+2])
                         ^ xtime(w_shift[4*c+3]) ^ w_shift[4*c+3];
            w_mix[4*c+3] = xtime(w_shift[4*c]) ^ w_shift[4*c] ^ w_shift[4*c+1]
                         ^ w_shift[4*c+2] ^ xtime(w_shift[4*c+3]);
        end
    end

    always_comb begin
        w_pre = '0;
        for (int k = 0; k < 16; k++)
            w_pre[127-8*k -: 8] = (round == 4'd10) ? w_shift[k] : w_mix[k];
    end

    assign state_out = w_pre ^ key_in;

endmodule

// File: rtl/aes128_iter_ctrl_key_step.sv
// On-the-fly AES-128 key expansion: derives the next round key from the current one.
module aes128_iter_ctrl_key_step
    import aes128_iter_ctrl_pkg::*;
(
    input  logic [BLK_W-1:0] i_rk,
    input  logic [7:0]       i_rcon,
    output logic [BLK_W-1:0] o_rk_next
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = i_rk;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_t   = {sbox(w_rot[31:24]) ^ i_rcon, sbox(w_rot[23:16]),
                    sbox(w_rot[15:8]), sbox(w_rot[7:0])};

    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_rk_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock through AES_Enc, round keys derived
// on the fly, valid/ready handshakes on both the input pair and the ciphertext.
module aes128_iter_ctrl #(
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst,
    aes128_iter_ctrl_if.slave  bus
);
    import aes128_iter_ctrl_pkg::*;

    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes128_iter_ctrl: only NR=10 (AES-128) is supported");
        end
    endgenerate

    state_t           r_fsm;
    logic [BLK_W-1:0] r_state;
    logic [BLK_W-1:0] r_rk;
    logic [BLK_W-1:0] r_ct;
    logic [3:0]       r_round;
    logic             r_out_valid;

    logic [BLK_W-1:0] w_rk_next;
    logic [BLK_W-1:0] w_round_out;

    aes128_iter_ctrl_key_step u_key_step (
        .i_rk      (r_rk),
        .i_rcon    (rcon(r_round)),
        .o_rk_next (w_rk_next)
    );

    AES_Enc u_round (
        .state_in  (r_state),
        .key_in    (w_rk_next),
        .round     (r_round),
        .state_out (w_round_out)
    );

    // The round counter runs 1..10 in RUN and parks at 11 in DONE until the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_rk        <= '0;
            r_ct        <= '0;
            r_round     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= bus.pt_in ^ bus.key_in;
                        r_rk    <= bus.key_in;
                        r_round <= 4'd1;
                        r_fsm   <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_round_out;
                    r_rk    <= w_rk_next;
                    r_round <= r_round + 4'd1;
                    if (r_round == 4'(NR)) begin
                        r_ct        <= w_round_out;
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_round     <= '0;
                        r_fsm       <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_fsm == IDLE);
    assign bus.busy      = (r_fsm == RUN);
    assign bus.out_valid = r_out_valid;
    assign bus.ct_out    = r_ct;
    assign bus.round_o   = r_round;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed and randomised checks of aes128_iter_ctrl against FIPS-197 vectors
// and an independent table-driven AES-128 model.
module tb_aes128_iter_ctrl;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   localparam logic [2047:0] SBOX_FLAT = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checkCount   = 0;
   int   errorCount   = 0;
   int   cycleCount   = 0;
   int   acceptCycle  = 0;
   int   overlapCount = 0;

   always #5 clk = ~clk;

   aes128_iter_ctrl_if bus();

   aes128_iter_ctrl #(.NR(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running edge counter used to measure latency and initiation interval.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Accepting and presenting a result in the same cycle is never allowed.
   always @(negedge clk) if (!rst && bus.in_ready && bus.out_valid) overlapCount++;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] sb(input logic [7:0] x);
      return SBOX_FLAT[2047 - 8*x -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] x);
      return x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
   endfunction

   function automatic logic [127:0] aesModel(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] k [16];
      logic [7:0] tmp [4];
      logic [7:0] rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
         k[i] = key[127-8*i -: 8];
      end
      rc = 8'h01;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         tmp[0] = sb(k[13]) ^ rc;
         tmp[1] = sb(k[14]);
         tmp[2] = sb(k[15]);
         tmp[3] = sb(k[12]);
         for (int i = 0; i < 4; i++) k[i] = k[i] ^ tmp[i];
         for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
         for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[4*c+r] = t[4*((c+r)%4)+r];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
         rc = xt(rc);
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic waitEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Presents a pair and returns just after the edge that accepted it.
   task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt, input bit holdValid);
      bit wasReady;
      int guard;
      bus.key_in   = key;
      bus.pt_in    = pt;
      bus.in_valid = 1'b1;
      wasReady = 1'b0;
      guard    = 0;
      while (!wasReady && guard < 100) begin
         wasReady = bus.in_ready;
         waitEdge();
         guard++;
      end
      checkOutput("accept", 128'(wasReady), 128'd1);
      acceptCycle = cycleCount;
      if (!holdValid) bus.in_valid = 1'b0;
   endtask

   // Latency counts edges from the accept edge (inclusive) to the edge raising out_valid.
   task automatic waitResult(output logic [127:0] ct, output int latency);
      int guard;
      guard = 0;
      while (!bus.out_valid && guard < 100) begin
         waitEdge();
         guard++;
      end
      checkOutput("out_valid_seen", 128'(bus.out_valid), 128'd1);
      ct      = bus.ct_out;
      latency = cycleCount - acceptCycle + 1;
   endtask

   initial begin
      logic [127:0] ct, key, pt;
      int lat, guard, firstAccept, seen, stall;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.pt_in     = '0;
      bus.key_in    = '0;

      // Reset state
      rst = 1'b1;
      repeat (2) waitEdge();
      checkOutput("rst_in_ready", 128'(bus.in_ready), 128'd1);
      checkOutput("rst_out_valid", 128'(bus.out_valid), 128'd0);
      checkOutput("rst_busy", 128'(bus.busy), 128'd0);
      checkOutput("rst_round", 128'(bus.round_o), 128'd0);
      checkOutput("rst_ct", bus.ct_out, 128'd0);
      rst = 1'b0;
      waitEdge();

      // FIPS-197 Appendix B
      bus.out_ready = 1'b1;
      applyStimulus(KEY_B, PT_B, 1'b0);
      checkOutput("run_busy", 128'(bus.busy), 128'd1);
      checkOutput("run_in_ready", 128'(bus.in_ready), 128'd0);
      checkOutput("run_round1", 128'(bus.round_o), 128'd1);
      waitResult(ct, lat);
      checkOutput("appB_ct", ct, CT_B);
      checkOutput("appB_latency", 128'(lat), 128'd11);
      checkOutput("appB_round_done", 128'(bus.round_o), 128'd11);
      checkOutput("appB_rk10", dut.r_rk, RK10_B);
      waitEdge();
      checkOutput("appB_idle_ready", 128'(bus.in_ready), 128'd1);
      checkOutput("appB_idle_valid", 128'(bus.out_valid), 128'd0);
      checkOutput("appB_idle_round", 128'(bus.round_o), 128'd0);

      // FIPS-197 Appendix C.1
      applyStimulus(KEY_C, PT_C, 1'b0);
      waitResult(ct, lat);
      checkOutput("appC_ct", ct, CT_C);
      checkOutput("appC_latency", 128'(lat), 128'd11);
      waitEdge();

      // Backpressure: result held for 20 stalled cycles, new pairs ignored
      bus.out_ready = 1'b0;
      applyStimulus(KEY_B, PT_B, 1'b0);
      waitResult(ct, lat);
      bus.key_in   = KEY_C;
      bus.pt_in    = PT_C;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         waitEdge();
         checkOutput("stall_ct", bus.ct_out, CT_B);
         checkOutput("stall_valid", 128'(bus.out_valid), 128'd1);
         checkOutput("stall_in_ready", 128'(bus.in_ready), 128'd0);
      end
      bus.out_ready = 1'b1;
      waitEdge();
      bus.in_valid = 1'b0;
      checkOutput("release_in_ready", 128'(bus.in_ready), 128'd1);
      checkOutput("release_valid", 128'(bus.out_valid), 128'd0);

      // Back-to-back with in_valid held; inputs change during RUN
      applyStimulus(KEY_B, PT_B, 1'b1);
      firstAccept  = acceptCycle;
      bus.key_in   = KEY_C;
      bus.pt_in    = PT_C;
      waitResult(ct, lat);
      checkOutput("b2b_first_ct", ct, CT_B);
      guard = 0;
      while (!bus.busy && guard < 20) begin
         waitEdge();
         guard++;
      end
      checkOutput("b2b_second_round", 128'(bus.round_o), 128'd1);
      checkOutput("b2b_interval", 128'(cycleCount - firstAccept), 128'd12);
      acceptCycle  = cycleCount;
      bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
      bus.pt_in    = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid = 1'b0;
      waitResult(ct, lat);
      checkOutput("b2b_second_ct", ct, CT_C);
      waitEdge();

      // Reset mid-operation, then reset racing an input pair
      applyStimulus(KEY_B, PT_B, 1'b0);
      guard = 0;
      while (bus.round_o != 4'd5 && guard < 20) begin
         waitEdge();
         guard++;
      end
      checkOutput("mid_round5", 128'(bus.round_o), 128'd5);
      rst = 1'b1;
      waitEdge();
      checkOutput("mid_rst_valid", 128'(bus.out_valid), 128'd0);
      checkOutput("mid_rst_ct", bus.ct_out, 128'd0);
      checkOutput("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
      checkOutput("mid_rst_busy", 128'(bus.busy), 128'd0);
      checkOutput("mid_rst_round", 128'(bus.round_o), 128'd0);
      bus.key_in   = KEY_C;
      bus.pt_in    = PT_C;
      bus.in_valid = 1'b1;
      waitEdge();
      checkOutput("rst_beats_valid", 128'(bus.busy), 128'd0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      seen = 0;
      repeat (15) begin
         waitEdge();
         if (bus.out_valid) seen++;
      end
      checkOutput("no_spurious_valid", 128'(seen), 128'd0);
      applyStimulus(KEY_B, PT_B, 1'b0);
      waitResult(ct, lat);
      checkOutput("post_rst_ct", ct, CT_B);
      waitEdge();

      // Random pairs with random consumer stalls
      for (int n = 0; n < 1000; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         bus.out_ready = 1'b0;
         applyStimulus(key, pt, 1'b0);
         waitResult(ct, lat);
         checkOutput("rand_ct", ct, aesModel(key, pt));
         stall = $urandom_range(0, 3);
         repeat (stall) waitEdge();
         bus.out_ready = 1'b1;
         waitEdge();
      end
      checkOutput("ready_valid_overlap", 128'(overlapCount), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
